branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries (power of two).
REQ-002 SHALL have parameter PHT_ENTRIES, default 64, number of 2-bit PHT counters (power of two).
REQ-003 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port fetch_pc_i  in  32  word-aligned PC of fetch slot 0; slot 1 PC = fetch_pc_i+4.
REQ-006 SHALL have port pred_taken_o  out  1  a taken branch is predicted in the fetch pair.
REQ-007 SHALL have port pred_slot_o  out  1  slot of the predicted-taken branch (0/1); 0 when pred_taken_o=0.
REQ-008 SHALL have port pred_tgt_o  out  32  predicted target; 0 when pred_taken_o=0.
REQ-009 SHALL have port update_pht_i  in  1  resolved branch/jump in execute slot 0.
REQ-010 SHALL have port update_btb_i  in  1  BTB write request, taken with target mismatch.
REQ-011 SHALL have port upd_pc_i  in  32  PC of the resolved instruction.
REQ-012 SHALL have port corr_taken_i  in  1  resolved direction.
REQ-013 SHALL have port corr_tgt_i  in  32  resolved target.
REQ-014 SHALL have port wrong_pred_i  in  1  misprediction flag from execute.
REQ-015 SHALL have port mispred_cnt_o  out  32  saturating misprediction count.

Function
REQ-016 SHALL index the BTB with pc[BI+1:2], BI=log2(BTB_ENTRIES), and tag with pc[31:BI+2]; each entry holds valid, tag, target.
REQ-017 SHALL index the PHT with pc[PI+1:2], PI=log2(PHT_ENTRIES).
REQ-018 SHALL predict a slot taken iff its BTB entry is valid, its tag matches, and its PHT counter bit[1]=1.
REQ-019 SHALL compute lookup combinationally from current table state, zero-cycle latency.
REQ-020 SHALL give slot 0 priority: if slot 0 is predicted taken, slot 1 is ignored and pred_slot_o=0.
REQ-021 SHALL produce pred_tgt_o from the BTB target of the selected slot.
REQ-022 SHALL update on the clock edge when update_pht_i=1: counter +1 saturating at 3 if corr_taken_i, else -1 saturating at 0.
REQ-023 SHALL write the BTB on the clock edge when update_btb_i=1: valid=1, tag and target from upd_pc_i/corr_tgt_i, overwriting any existing entry.
REQ-024 SHALL ignore update_btb_i when update_pht_i=0.
REQ-025 SHALL NOT bypass same-cycle updates into lookup; an update is visible to lookup from the next cycle.
REQ-026 SHALL update independent PHT and BTB indices in the same cycle without interference.
REQ-027 SHALL increment mispred_cnt_o by 1 per cycle with wrong_pred_i=1 and update_pht_i=1, saturating at 32'hFFFF_FFFF.

Reset
REQ-028 SHALL, on rst_i=1 at a clock edge, clear all BTB valid bits, set all PHT counters to 2'b01 (weakly not-taken), and clear mispred_cnt_o to 0.
REQ-029 SHALL give reset priority over simultaneous updates; updates presented in the reset cycle are lost.
REQ-030 SHALL, after reset, drive pred_taken_o=0, pred_slot_o=0 and pred_tgt_o=0 for every fetch_pc_i until a BTB write occurs.

Structure
REQ-031 SHALL keep 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11) and default table sizes in the shared defines file.
REQ-032 SHALL implement the saturating counter next-state as one sub-module, sat_counter2, instantiated combinationally on the update path.

Verification
REQ-033 SHALL check: reset, then fetch_pc_i=0x100 -> pred_taken_o=0, pred_tgt_o=0.
REQ-034 SHALL check: update upd_pc_i=0x100, corr_taken=1, btb=1, tgt=0x200; next cycle fetch 0x100 -> taken, slot 0, tgt 0x200 (counter 01->10).
REQ-035 SHALL check: three not-taken updates at 0x100 -> counter 00; a fourth stays 00; fetch 0x100 -> pred_taken_o=0.
REQ-036 SHALL check: BTB entry at 0x104 taken, tgt 0x300; fetch 0x100 with slot 0 not predicted -> taken, slot 1, tgt 0x300.
REQ-037 SHALL check: aliasing upd_pc_i=0x140 (same BTB index as 0x100, different tag) -> fetch 0x100 misses.
REQ-038 SHALL check: update and fetch of 0x100 in the same cycle -> old prediction that cycle, new prediction next cycle; rst_i with update_btb_i=1 leaves the BTB empty.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the branch predictor:
//   - default BTB / PHT table sizes
//   - 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   - helper that reads the taken/not-taken decision out of a counter
// No ports; imported by branch_predictor and sat_counter2.
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam int DEFAULT_BTB_ENTRIES = 16;
    localparam int DEFAULT_PHT_ENTRIES = 64;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,   // strongly not-taken
        CNT_WNT = 2'b01,   // weakly not-taken (reset value)
        CNT_WT  = 2'b10,   // weakly taken
        CNT_ST  = 2'b11    // strongly taken
    } cnt2_e;

    // The MSB of the counter is the direction decision.
    function automatic logic cnt_predicts_taken(input cnt2_e cnt);
        return cnt[1];
    endfunction

endpackage : branch_predictor_pkg

// File: rtl/branch_predictor_sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// Purely combinational next-state function of a 2-bit saturating counter.
// Ports:
//   cnt_i  - current counter value
//   inc_i  - 1: count towards ST (saturate at 11), 0: count towards SNT
//            (saturate at 00)
//   cnt_o  - next counter value
// ---------------------------------------------------------------------------
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  cnt2_e cnt_i,
    input  logic  inc_i,
    output cnt2_e cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != CNT_ST) begin
                cnt_o = cnt2_e'(cnt_i + 2'd1);
            end
        end else begin
            if (cnt_i != CNT_SNT) begin
                cnt_o = cnt2_e'(cnt_i - 2'd1);
            end
        end
    end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Two-slot fetch branch predictor: a direct-mapped BTB (valid/tag/target)
// plus a PHT of 2-bit saturating counters. Lookup is combinational on the
// current table contents; updates from execute are written on the clock
// edge and become visible to lookup on the following cycle.
//
// Ports:
//   clk_i          - clock, all state updates on rising edge
//   rst_i          - synchronous active-high reset
//   fetch_pc_i     - PC of fetch slot 0 (slot 1 is fetch_pc_i + 4)
//   pred_taken_o   - some slot of the fetch pair is predicted taken
//   pred_slot_o    - slot of the predicted-taken branch (0 if none)
//   pred_tgt_o     - predicted target (0 if none)
//   update_pht_i   - a branch/jump resolved in execute slot 0
//   update_btb_i   - write the BTB for that branch (only with update_pht_i)
//   upd_pc_i       - PC of the resolved instruction
//   corr_taken_i   - resolved direction
//   corr_tgt_i     - resolved target
//   wrong_pred_i   - resolved branch was mispredicted
//   mispred_cnt_o  - saturating misprediction counter
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = DEFAULT_BTB_ENTRIES,
    parameter int PHT_ENTRIES = DEFAULT_PHT_ENTRIES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_taken_o,
    output logic        pred_slot_o,
    output logic [31:0] pred_tgt_o,
    input  logic        update_pht_i,
    input  logic        update_btb_i,
    input  logic [31:0] upd_pc_i,
    input  logic        corr_taken_i,
    input  logic [31:0] corr_tgt_i,
    input  logic        wrong_pred_i,
    output logic [31:0] mispred_cnt_o
);

    localparam int BI    = $clog2(BTB_ENTRIES);
    localparam int PI    = $clog2(PHT_ENTRIES);
    localparam int TAG_W = 30 - BI;   // pc[31:BI+2]

    // -----------------------------------------------------------------------
    // Table state
    // -----------------------------------------------------------------------
    logic              btb_valid_q [BTB_ENTRIES];
    logic              btb_valid_d [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q   [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_d   [BTB_ENTRIES];
    logic [31:0]       btb_tgt_q   [BTB_ENTRIES];
    logic [31:0]       btb_tgt_d   [BTB_ENTRIES];
    cnt2_e             pht_q       [PHT_ENTRIES];
    cnt2_e             pht_d       [PHT_ENTRIES];
    logic [31:0]       mispred_cnt_q;
    logic [31:0]       mispred_cnt_d;

    // Byte-offset bits of a word-aligned PC carry no information.
    logic [3:0] unused_pc_bits;
    assign unused_pc_bits = {fetch_pc_i[1:0], upd_pc_i[1:0]};

    // -----------------------------------------------------------------------
    // Lookup: both fetch slots in parallel, working on word addresses so the
    // +4 for slot 1 becomes +1.
    // -----------------------------------------------------------------------
    logic [29:0] fetch_word;
    logic        slot_hit [2];
    logic [31:0] slot_tgt [2];

    assign fetch_word = fetch_pc_i[31:2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [29:0]      slot_word;
        logic [BI-1:0]    slot_btb_idx;
        logic [PI-1:0]    slot_pht_idx;
        logic [TAG_W-1:0] slot_tag;

        assign slot_word    = fetch_word + 30'(gi);
        assign slot_btb_idx = slot_word[BI-1:0];
        assign slot_pht_idx = slot_word[PI-1:0];
        assign slot_tag     = slot_word[29:BI];

        assign slot_hit[gi] = btb_valid_q[slot_btb_idx]
                           && (btb_tag_q[slot_btb_idx] == slot_tag)
                           && cnt_predicts_taken(pht_q[slot_pht_idx]);
        assign slot_tgt[gi] = btb_tgt_q[slot_btb_idx];
    end

    // Slot 0 wins when both slots hit; outputs are forced to 0 on no hit.
    always_comb begin
        pred_taken_o = 1'b0;
        pred_slot_o  = 1'b0;
        pred_tgt_o   = 32'd0;
        if (slot_hit[0]) begin
            pred_taken_o = 1'b1;
            pred_tgt_o   = slot_tgt[0];
        end else if (slot_hit[1]) begin
            pred_taken_o = 1'b1;
            pred_slot_o  = 1'b1;
            pred_tgt_o   = slot_tgt[1];
        end
    end

    // -----------------------------------------------------------------------
    // Update path
    // -----------------------------------------------------------------------
    logic [29:0]      upd_word;
    logic [BI-1:0]    upd_btb_idx;
    logic [PI-1:0]    upd_pht_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             btb_we;
    cnt2_e            pht_cur;
    cnt2_e            pht_upd;

    assign upd_word    = upd_pc_i[31:2];
    assign upd_btb_idx = upd_word[BI-1:0];
    assign upd_pht_idx = upd_word[PI-1:0];
    assign upd_tag     = upd_word[29:BI];
    assign pht_cur     = pht_q[upd_pht_idx];

    // A BTB write is only meaningful for a resolved branch.
    assign btb_we = update_pht_i && update_btb_i;

    sat_counter2 u_sat_counter2 (
        .cnt_i (pht_cur),
        .inc_i (corr_taken_i),
        .cnt_o (pht_upd)
    );

    always_comb begin
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_d[i] = btb_valid_q[i];
            btb_tag_d[i]   = btb_tag_q[i];
            btb_tgt_d[i]   = btb_tgt_q[i];
        end
        if (btb_we) begin
            btb_valid_d[upd_btb_idx] = 1'b1;
            btb_tag_d[upd_btb_idx]   = upd_tag;
            btb_tgt_d[upd_btb_idx]   = corr_tgt_i;
        end
    end

    always_comb begin
        for (int i = 0; i < PHT_ENTRIES; i++) begin
            pht_d[i] = pht_q[i];
        end
        if (update_pht_i) begin
            pht_d[upd_pht_idx] = pht_upd;
        end
    end

    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (update_pht_i && wrong_pred_i && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers. Only the valid bits need clearing; tag/target of an
    // invalid entry are never observed.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= CNT_WNT;
            end
            mispred_cnt_q <= 32'd0;
        end else begin
            btb_valid_q   <= btb_valid_d;
            pht_q         <= pht_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end

    assign mispred_cnt_o = mispred_cnt_q;

endmodule : branch_predictor
